// File: rtl/noc_network_interface.sv
// noc_network_interface: bridges a core request/response port to the local
// port of a mesh router. Requests become single-flit packets tagged with an
// 8-bit pkt_id; a scoreboard of MAX_OUTSTANDING slots pairs responses with
// their requests.
// Optional feature: define NOC_NI_TIMEOUT_EN to add per-slot age counters
// that retire a request with an error response after TIMEOUT_CYCLES.
//
// Handshake rule for every valid/ready pair in this file: a transfer happens
// on the rising clock edge where valid and ready are both high. Once valid is
// raised, the payload stays stable until that transfer happens.

package noc_ni_pkg;

    typedef enum logic [1:0] {
        QOS_LOW    = 2'd0,
        QOS_NORMAL = 2'd1,
        QOS_HIGH   = 2'd2,
        QOS_URGENT = 2'd3
    } qos_level_t;

    typedef enum logic [2:0] {
        PKT_READ_REQ   = 3'd0,
        PKT_WRITE_REQ  = 3'd1,
        PKT_READ_RESP  = 3'd2,
        PKT_WRITE_RESP = 3'd3
    } pkt_type_t;

    typedef struct packed {
        logic       head;
        logic       tail;
        logic       multicast;
        logic [3:0] length;
        logic [3:0] src_x;
        logic [3:0] src_y;
        logic [3:0] dst_x;
        logic [3:0] dst_y;
        pkt_type_t  pkt_type;
        qos_level_t qos;
        logic [7:0] pkt_id;
    } noc_header_t;

    typedef struct packed {
        noc_header_t  header;
        logic [255:0] data;
    } noc_flit_t;

endpackage

module noc_network_interface
    import noc_ni_pkg::*;
#(
    parameter int X_COORD         = 0,
    parameter int Y_COORD         = 0,
    parameter int MESH_SIZE_X     = 4,
    parameter int MESH_SIZE_Y     = 4,
    parameter int MAX_OUTSTANDING = 8,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    // core request
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_write,
    input  logic [31:0]  req_addr,
    input  logic [255:0] req_wdata,
    input  qos_level_t   req_qos,
    // core response
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [255:0] rsp_data,
    output logic [7:0]   rsp_id,
    output logic         rsp_error,
    // router inject (to router DIR_LOCAL input)
    output noc_flit_t    flit_out,
    output logic         valid_out,
    input  logic         ready_in,
    // router eject (from router DIR_LOCAL output)
    input  noc_flit_t    flit_in,
    input  logic         valid_in,
    output logic         ready_out,
    // status / debug
    output logic [4:0]   outstanding_count,
    output logic         tx_state_dbg
);

    localparam int SLOT_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    // Elaboration-time parameter sanity checks.
    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 16 ||
        (MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0) begin : g_bad_max
        $error("MAX_OUTSTANDING must be a power of two between 1 and 16");
    end
    if (MESH_SIZE_X < 1 || MESH_SIZE_X > 16 || (MESH_SIZE_X & (MESH_SIZE_X - 1)) != 0 ||
        MESH_SIZE_Y < 1 || MESH_SIZE_Y > 16 || (MESH_SIZE_Y & (MESH_SIZE_Y - 1)) != 0) begin : g_bad_mesh
        $error("MESH_SIZE_X/Y must be powers of two no larger than 16");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_HOLD = 1'b1
    } tx_state_t;

    tx_state_t          state_q, state_d;
    noc_flit_t          flit_q, flit_d;
    logic [7:0]         pkt_id_cnt_q, pkt_id_cnt_d;
    logic [MAX_OUTSTANDING-1:0] busy_q, busy_d;
    logic [7:0]         slot_id_q [MAX_OUTSTANDING];
    logic [7:0]         slot_id_d [MAX_OUTSTANDING];
    logic [4:0]         count_q, count_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_error_q, rsp_error_d;
    logic [7:0]         rsp_id_q, rsp_id_d;
    logic [255:0]       rsp_data_q, rsp_data_d;

    logic [SLOT_W-1:0]  req_slot;
    logic [SLOT_W-1:0]  ej_slot;
    logic [SLOT_W-1:0]  to_slot;
    logic               req_accept;
    logic               ej_accept;
    logic               ej_match;
    logic               rsp_chan_free;
    logic               to_fire;
    logic               retire;
    noc_flit_t          new_flit;

    // Header fields a response never needs to look at.
    logic unused_flit_bits;
    assign unused_flit_bits = ^{flit_in.header.tail, flit_in.header.multicast,
                                flit_in.header.length, flit_in.header.src_x,
                                flit_in.header.src_y, flit_in.header.dst_x,
                                flit_in.header.dst_y, flit_in.header.qos};

    assign req_slot = SLOT_W'(pkt_id_cnt_q % 8'(MAX_OUTSTANDING));
    assign ej_slot  = SLOT_W'(flit_in.header.pkt_id % 8'(MAX_OUTSTANDING));

    // A request is taken only when the inject register can be refilled this
    // edge and the slot its pkt_id maps onto is free; all terms are pre-edge.
    assign req_ready  = rst_n && ((state_q == TX_IDLE) || ready_in) &&
                        !busy_q[req_slot] && (count_q < 5'(MAX_OUTSTANDING));
    assign req_accept = req_valid && req_ready;

    assign rsp_chan_free = !rsp_valid_q || rsp_ready;
    // A pending timeout owns the response register, so eject stalls then.
    assign ready_out     = rst_n && rsp_chan_free && !to_fire;
    assign ej_accept     = valid_in && ready_out;

    assign ej_match = flit_in.header.head &&
                      ((flit_in.header.pkt_type == PKT_READ_RESP) ||
                       (flit_in.header.pkt_type == PKT_WRITE_RESP)) &&
                      busy_q[ej_slot] &&
                      (slot_id_q[ej_slot] == flit_in.header.pkt_id);

`ifdef NOC_NI_TIMEOUT_EN
    localparam int AGE_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [AGE_W-1:0]           age_q [MAX_OUTSTANDING];
    logic [MAX_OUTSTANDING-1:0] expired;

    // The age counter of a slot reaches TIMEOUT_CYCLES on the edge where the
    // timeout response is registered, so expiry is flagged one count early.
    always_comb begin
        expired = '0;
        to_slot = '0;
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            expired[i] = busy_q[i] && (age_q[i] == AGE_W'(TIMEOUT_CYCLES - 1));
        end
        for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
            if (expired[i]) to_slot = SLOT_W'(i);
        end
    end

    assign to_fire = rsp_chan_free && (|expired);

    // Per-slot age: cleared when the slot is claimed, counts while busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) age_q[i] <= '0;
        end else begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                if (req_accept && (req_slot == SLOT_W'(i))) begin
                    age_q[i] <= '0;
                end else if (busy_q[i] && (age_q[i] < AGE_W'(TIMEOUT_CYCLES - 1))) begin
                    age_q[i] <= age_q[i] + AGE_W'(1);
                end
            end
        end
    end
`else
    assign to_fire = 1'b0;
    assign to_slot = '0;
`endif

    // Build the single-flit request packet from the core request.
    always_comb begin
        new_flit                  = '0;
        new_flit.header.head      = 1'b1;
        new_flit.header.tail      = 1'b1;
        new_flit.header.multicast = 1'b0;
        new_flit.header.length    = 4'd1;
        new_flit.header.src_x     = 4'(X_COORD);
        new_flit.header.src_y     = 4'(Y_COORD);
        new_flit.header.dst_x     = req_addr[31:28] & 4'(MESH_SIZE_X - 1);
        new_flit.header.dst_y     = req_addr[27:24] & 4'(MESH_SIZE_Y - 1);
        new_flit.header.pkt_type  = req_write ? PKT_WRITE_REQ : PKT_READ_REQ;
        new_flit.header.qos       = req_qos;
        new_flit.header.pkt_id    = pkt_id_cnt_q;
        new_flit.data             = req_write ? req_wdata : '0;
    end

    // TX state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= TX_IDLE;
        else        state_q <= state_d;
    end

    // TX next state: HOLD while a flit waits for the router.
    always_comb begin
        state_d = state_q;
        case (state_q)
            TX_IDLE: if (req_accept) state_d = TX_HOLD;
            TX_HOLD: if (ready_in && !req_accept) state_d = TX_IDLE;
            default: state_d = TX_IDLE;
        endcase
    end

    // TX outputs: a flit is on the link exactly while in HOLD.
    always_comb begin
        valid_out    = (state_q == TX_HOLD);
        tx_state_dbg = state_q;
        flit_d       = req_accept ? new_flit : flit_q;
    end

    // Inject flit register; only reloaded on a request accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) flit_q <= '0;
        else        flit_q <= flit_d;
    end

    assign flit_out = flit_q;

    // Scoreboard next state: one retirement (timeout or match) and one
    // allocation may happen together; they never touch the same slot.
    always_comb begin
        busy_d       = busy_q;
        slot_id_d    = slot_id_q;
        pkt_id_cnt_d = pkt_id_cnt_q;
        retire       = 1'b0;
        if (to_fire) begin
            busy_d[to_slot] = 1'b0;
            retire          = 1'b1;
        end else if (ej_accept && ej_match) begin
            busy_d[ej_slot] = 1'b0;
            retire          = 1'b1;
        end
        if (req_accept) begin
            busy_d[req_slot]    = 1'b1;
            slot_id_d[req_slot] = pkt_id_cnt_q;
            pkt_id_cnt_d        = pkt_id_cnt_q + 8'd1;
        end
        count_d = count_q + 5'(req_accept) - 5'(retire);
    end

    // Scoreboard registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q       <= '0;
            pkt_id_cnt_q <= '0;
            count_q      <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) slot_id_q[i] <= '0;
        end else begin
            busy_q       <= busy_d;
            pkt_id_cnt_q <= pkt_id_cnt_d;
            count_q      <= count_d;
            for (int i = 0; i < MAX_OUTSTANDING; i++) slot_id_q[i] <= slot_id_d[i];
        end
    end

    assign outstanding_count = count_q;

    // Response next state: timeout first, then eject, else drain on rsp_ready.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_error_d = rsp_error_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        if (to_fire) begin
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
            rsp_id_d    = slot_id_q[to_slot];
            rsp_data_d  = '0;
        end else if (ej_accept) begin
            rsp_valid_d = 1'b1;
            rsp_error_d = !ej_match;
            rsp_id_d    = flit_in.header.pkt_id;
            rsp_data_d  = flit_in.data;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // Response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_error_q <= rsp_error_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_error = rsp_error_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_noc_network_interface.sv
// Directed testbench for noc_network_interface (router at mesh (1,1),
// 4x4 mesh, 8 slots). Inputs change on the falling edge; outputs are read on
// the falling edge or 1 ns after an input change.
module tb_noc_network_interface;
    import noc_ni_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid, req_ready, req_write;
    logic [31:0]  req_addr;
    logic [255:0] req_wdata;
    qos_level_t   req_qos;
    logic         rsp_valid, rsp_ready, rsp_error;
    logic [255:0] rsp_data;
    logic [7:0]   rsp_id;
    noc_flit_t    flit_out, flit_in;
    logic         valid_out, ready_in, valid_in, ready_out;
    logic [4:0]   outstanding_count;
    logic         tx_state_dbg;

    int errors = 0;
    int checks = 0;

    localparam logic [255:0] D1 = {8{32'hDEAD_0001}};
    localparam logic [255:0] D2 = {8{32'hBEEF_0002}};
    localparam logic [255:0] WD = {8{32'hA5A5_1234}};

    noc_network_interface #(
        .X_COORD(1), .Y_COORD(1), .MESH_SIZE_X(4), .MESH_SIZE_Y(4),
        .MAX_OUTSTANDING(8), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_qos(req_qos),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .rsp_error(rsp_error),
        .flit_out(flit_out), .valid_out(valid_out), .ready_in(ready_in),
        .flit_in(flit_in), .valid_in(valid_in), .ready_out(ready_out),
        .outstanding_count(outstanding_count), .tx_state_dbg(tx_state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Expected request flit from this router at (1,1), fields hand-supplied.
    function automatic noc_flit_t mk_flit(input pkt_type_t t, input logic [3:0] dx,
                                          input logic [3:0] dy, input qos_level_t q,
                                          input logic [7:0] id, input logic [255:0] d);
        noc_flit_t f;
        f = '0;
        f.header.head = 1'b1;
        f.header.tail = 1'b1;
        f.header.length = 4'd1;
        f.header.src_x = 4'd1;
        f.header.src_y = 4'd1;
        f.header.dst_x = dx;
        f.header.dst_y = dy;
        f.header.pkt_type = t;
        f.header.qos = q;
        f.header.pkt_id = id;
        f.data = d;
        return f;
    endfunction

    task automatic idle_inputs();
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        req_qos = QOS_LOW; rsp_ready = 1'b0; ready_in = 1'b1;
        flit_in = '0; valid_in = 1'b0;
    endtask

    task automatic drive_eject(input pkt_type_t t, input logic [7:0] id, input logic [255:0] d);
        flit_in = '0;
        flit_in.header.head = 1'b1;
        flit_in.header.tail = 1'b1;
        flit_in.header.length = 4'd1;
        flit_in.header.pkt_type = t;
        flit_in.header.pkt_id = id;
        flit_in.data = d;
        valid_in = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid_out: got %b expected 0", valid_out); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
        checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL reset_ready_out: got %b expected 0", ready_out); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        checks++; if (outstanding_count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", outstanding_count); end
        checks++; if (flit_out !== '0) begin errors++; $display("FAIL reset_flit: got %h expected 0", flit_out); end
        rst_n = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_req_ready: got %b expected 1", req_ready); end
        checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL post_reset_ready_out: got %b expected 1", ready_out); end
    endtask

    noc_flit_t held_flit;

    task automatic test_read_inject();
        @(negedge clk);
        ready_in = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h2100_0000;
        req_wdata = WD; req_qos = QOS_URGENT;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        held_flit = mk_flit(PKT_READ_REQ, 4'd2, 4'd1, QOS_URGENT, 8'd0, '0);
        checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL read_valid_out: got %b expected 1", valid_out); end
        checks++; if (flit_out !== held_flit) begin errors++; $display("FAIL read_flit: got %h expected %h", flit_out, held_flit); end
        checks++; if (outstanding_count !== 5'd1) begin errors++; $display("FAIL read_count: got %0d expected 1", outstanding_count); end
    endtask

    task automatic test_stall();
        noc_flit_t exp_w;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h3200_0000;
        req_wdata = WD; req_qos = QOS_HIGH;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL stall_req_ready[%0d]: got %b expected 0", i, req_ready); end
            checks++; if (flit_out !== held_flit || valid_out !== 1'b1) begin errors++; $display("FAIL stall_flit[%0d]: got %h/%b expected %h/1", i, flit_out, valid_out, held_flit); end
            @(posedge clk);
            @(negedge clk);
        end
        ready_in = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL release_req_ready: got %b expected 1", req_ready); end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        exp_w = mk_flit(PKT_WRITE_REQ, 4'd3, 4'd2, QOS_HIGH, 8'd1, WD);
        checks++; if (flit_out !== exp_w || valid_out !== 1'b1) begin errors++; $display("FAIL write_flit: got %h/%b expected %h/1", flit_out, valid_out, exp_w); end
        checks++; if (outstanding_count !== 5'd2) begin errors++; $display("FAIL write_count: got %0d expected 2", outstanding_count); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL drained_valid_out: got %b expected 0", valid_out); end
    endtask

    task automatic test_back_to_back();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h1000_0000; req_qos = QOS_NORMAL;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (valid_out !== 1'b1 || flit_out.header.pkt_id !== 8'(2 + i)) begin
                errors++; $display("FAIL b2b_pkt_id[%0d]: got %b/%0d expected 1/%0d", i, valid_out, flit_out.header.pkt_id, 2 + i);
            end
        end
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL full_req_ready: got %b expected 0", req_ready); end
        checks++; if (outstanding_count !== 5'd8) begin errors++; $display("FAIL full_count: got %0d expected 8", outstanding_count); end
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_response();
        rsp_ready = 1'b0;
        drive_eject(PKT_READ_RESP, 8'd3, D1);
        #1;
        checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL rsp_ready_out: got %b expected 1", ready_out); end
        @(posedge clk);
        @(negedge clk);
        valid_in = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 8'd3 || rsp_error !== 1'b0) begin errors++; $display("FAIL rsp3: got v=%b id=%0d err=%b expected v=1 id=3 err=0", rsp_valid, rsp_id, rsp_error); end
        checks++; if (rsp_data !== D1) begin errors++; $display("FAIL rsp3_data: got %h expected %h", rsp_data, D1); end
        checks++; if (outstanding_count !== 5'd7) begin errors++; $display("FAIL rsp3_count: got %0d expected 7", outstanding_count); end
        req_valid = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL slot0_busy_req_ready: got %b expected 0", req_ready); end
        req_valid = 1'b0;
    endtask

    task automatic test_rsp_backpressure();
        drive_eject(PKT_WRITE_RESP, 8'd0, D2);
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL bp_ready_out[%0d]: got %b expected 0", i, ready_out); end
            checks++; if (rsp_data !== D1 || rsp_id !== 8'd3 || rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_hold[%0d]: got id=%0d v=%b expected id=3 v=1", i, rsp_id, rsp_valid); end
            @(posedge clk);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL bp_release_ready_out: got %b expected 1", ready_out); end
        @(posedge clk);
        @(negedge clk);
        valid_in = 1'b0;
        checks++; if (rsp_id !== 8'd0 || rsp_data !== D2 || rsp_error !== 1'b0) begin errors++; $display("FAIL rsp0: got id=%0d err=%b expected id=0 err=0", rsp_id, rsp_error); end
        checks++; if (outstanding_count !== 5'd6) begin errors++; $display("FAIL rsp0_count: got %0d expected 6", outstanding_count); end
        req_valid = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL slot0_free_req_ready: got %b expected 1", req_ready); end
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rsp_drain: got %b expected 0", rsp_valid); end
    endtask

    task automatic test_unexpected();
        rsp_ready = 1'b1;
        drive_eject(PKT_READ_RESP, 8'h55, D1);
        @(posedge clk);
        @(negedge clk);
        valid_in = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b1 || rsp_id !== 8'h55) begin errors++; $display("FAIL unexp55: got v=%b err=%b id=%h expected 1/1/55", rsp_valid, rsp_error, rsp_id); end
        checks++; if (outstanding_count !== 5'd6) begin errors++; $display("FAIL unexp55_count: got %0d expected 6", outstanding_count); end
        drive_eject(PKT_READ_REQ, 8'd2, D1);
        @(posedge clk);
        @(negedge clk);
        valid_in = 1'b0;
        checks++; if (rsp_error !== 1'b1 || outstanding_count !== 5'd6) begin errors++; $display("FAIL wrong_type: got err=%b cnt=%0d expected 1/6", rsp_error, outstanding_count); end
        drive_eject(PKT_READ_RESP, 8'd2, D2);
        @(posedge clk);
        @(negedge clk);
        valid_in = 1'b0;
        checks++; if (rsp_error !== 1'b0 || rsp_id !== 8'd2 || outstanding_count !== 5'd5) begin errors++; $display("FAIL match2: got err=%b id=%0d cnt=%0d expected 0/2/5", rsp_error, rsp_id, outstanding_count); end
    endtask

    task automatic test_reset_mid();
        ready_in = 1'b0; rsp_ready = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0000;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        checks++; if (valid_out !== 1'b1 || outstanding_count !== 5'd6) begin errors++; $display("FAIL pre_reset_hold: got v=%b cnt=%0d expected 1/6", valid_out, outstanding_count); end
        rst_n = 1'b0;
        #1;
        checks++; if (valid_out !== 1'b0 || flit_out !== '0 || outstanding_count !== 5'd0) begin errors++; $display("FAIL mid_reset_clear: got v=%b cnt=%0d expected 0/0", valid_out, outstanding_count); end
        checks++; if (req_ready !== 1'b0 || ready_out !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_ready: got %b/%b/%b expected 0/0/0", req_ready, ready_out, rsp_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        ready_in = 1'b1; rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (valid_out !== 1'b0 || rsp_valid !== 1'b0 || outstanding_count !== 5'd0) begin errors++; $display("FAIL post_mid_reset: got v=%b rv=%b cnt=%0d expected 0/0/0", valid_out, rsp_valid, outstanding_count); end
    endtask

    task automatic test_id_wrap();
        logic [7:0] exp_id;
        for (int i = 0; i < 300; i++) begin
            exp_id = 8'(i);
            req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0100_0000;
            @(posedge clk);
            @(negedge clk);
            req_valid = 1'b0;
            checks++;
            if (valid_out !== 1'b1 || flit_out.header.pkt_id !== exp_id) begin
                errors++; $display("FAIL wrap_pkt_id[%0d]: got %b/%0d expected 1/%0d", i, valid_out, flit_out.header.pkt_id, exp_id);
            end
            drive_eject(PKT_READ_RESP, exp_id, {8{i}});
            @(posedge clk);
            @(negedge clk);
            valid_in = 1'b0;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== exp_id || rsp_error !== 1'b0 || rsp_data !== {8{i}}) begin
                errors++; $display("FAIL wrap_rsp[%0d]: got v=%b id=%0d err=%b expected 1/%0d/0", i, rsp_valid, rsp_id, rsp_error, exp_id);
            end
        end
        checks++; if (outstanding_count !== 5'd0) begin errors++; $display("FAIL wrap_count: got %0d expected 0", outstanding_count); end
    endtask

`ifdef NOC_NI_TIMEOUT_EN
    task automatic test_timeout();
        int seen;
        logic ro, ro_fire;
        seen = 0; ro_fire = 1'b1;
        rsp_ready = 1'b1; ready_in = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0000;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            ro = ready_out;
            @(posedge clk);
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                seen = k; ro_fire = ro;
                break;
            end
        end
        checks++; if (seen !== 16) begin errors++; $display("FAIL timeout_cycle: got %0d expected 16", seen); end
        checks++; if (ro_fire !== 1'b0) begin errors++; $display("FAIL timeout_ready_out: got %b expected 0", ro_fire); end
        checks++; if (rsp_error !== 1'b1 || rsp_id !== 8'd0) begin errors++; $display("FAIL timeout_rsp: got err=%b id=%0d expected 1/0", rsp_error, rsp_id); end
        checks++; if (rsp_data !== '0) begin errors++; $display("FAIL timeout_data: got %h expected 0", rsp_data); end
        checks++; if (outstanding_count !== 5'd0) begin errors++; $display("FAIL timeout_count: got %0d expected 0", outstanding_count); end
    endtask
`endif

    initial begin
        test_reset();
`ifdef NOC_NI_TIMEOUT_EN
        test_timeout();
`else
        test_read_inject();
        test_stall();
        test_back_to_back();
        test_response();
        test_rsp_backpressure();
        test_unexpected();
        test_reset_mid();
        test_id_wrap();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
